// File: rtl/ddr_rd_tracker_pkg.sv
// Shared definitions for the two-requester DDR read tracker: widths, requester
// ID encoding and outstanding-capacity derivation.
package ddr_rd_tracker_pkg;

  localparam int unsigned DDR_ADDR_W = 32;
  localparam int unsigned DDR_DATA_W = 256;
  localparam int unsigned TAG_PTR_W  = 8;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  function automatic int unsigned max_out(input int unsigned ptr_w);
    return 32'd1 << ptr_w;
  endfunction

endpackage

// File: rtl/ddr_rd_tracker_rd_tag_ram.sv
// Requester-ID tag store: one bit per outstanding command, synchronous write,
// asynchronous read, intentionally not reset.
module ddr_rd_tracker_rd_tag_ram #(
  parameter int unsigned PTR_W = 8
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic             i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic             o_rdata
);

  logic mem_q [2**PTR_W];

  // Tag write on grant; contents are only meaningful between wr_ptr and rd_ptr.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/ddr_rd_tracker.sv
// Round-robin DDR read scheduler for two requesters with in-order routing of
// returned data back to the requester that issued each command.
module ddr_rd_tracker
  import ddr_rd_tracker_pkg::*;
#(
  parameter int unsigned ADDR_W = DDR_ADDR_W,
  parameter int unsigned DATA_W = DDR_DATA_W,
  parameter int unsigned PTR_W  = TAG_PTR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic              i_req1_valid,
  input  logic [ADDR_W-1:0] i_req1_addr,
  output logic              o_req0_ready,
  output logic              o_req1_ready,
  output logic              o_ddr_cmd_valid,
  output logic [ADDR_W-1:0] o_ddr_cmd_addr,
  input  logic              i_ddr_cmd_ready,
  input  logic              i_ddr_rd_valid,
  input  logic [DATA_W-1:0] i_ddr_rd_data,
  input  logic              i_ddr_rd_last,
  output logic              o_rd0_valid,
  output logic              o_rd1_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_last,
  output logic [PTR_W:0]    o_outstanding,
  output logic              o_full,
  output logic              o_err
);

  localparam logic [PTR_W:0] MaxCnt = (PTR_W+1)'(max_out(PTR_W));
  localparam logic [PTR_W:0] CntOne = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PtrOne = PTR_W'(1);

  logic              cmd_valid_q, cmd_valid_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic              rd0_valid_q, rd0_valid_d;
  logic              rd1_valid_q, rd1_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_last_q, rd_last_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  req_id_e           last_grant_q, last_grant_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  logic    slot_free_s;
  logic    grant_s;
  req_id_e gnt_id_s;
  logic    owner_s;
  logic    accept_s;
  logic    retire_s;

  ddr_rd_tracker_rd_tag_ram #(.PTR_W(PTR_W)) u_tag_ram (
    .i_clk   (i_clk),
    .i_we    (grant_s),
    .i_waddr (wr_ptr_q),
    .i_wdata (logic'(gnt_id_s)),
    .i_raddr (rd_ptr_q),
    .o_rdata (owner_s)
  );

  // Arbitration, return steering and next-state for every register.
  always_comb begin
    slot_free_s = !cmd_valid_q || i_ddr_cmd_ready;
    case ({i_req1_valid, i_req0_valid})
      2'b11:   gnt_id_s = (last_grant_q == REQ0) ? REQ1 : REQ0;
      2'b10:   gnt_id_s = REQ1;
      default: gnt_id_s = REQ0;
    endcase
    grant_s = slot_free_s && !full_q && (i_req0_valid || i_req1_valid);

    // A beat with nothing outstanding has no owner: flag it and drop it.
    accept_s = i_ddr_rd_valid && (count_q != '0);
    retire_s = accept_s && i_ddr_rd_last;

    cmd_valid_d  = cmd_valid_q;
    cmd_addr_d   = cmd_addr_q;
    last_grant_d = last_grant_q;
    wr_ptr_d     = wr_ptr_q;
    if (grant_s) begin
      cmd_valid_d  = 1'b1;
      cmd_addr_d   = (gnt_id_s == REQ1) ? i_req1_addr : i_req0_addr;
      last_grant_d = gnt_id_s;
      wr_ptr_d     = wr_ptr_q + PtrOne;
    end else if (slot_free_s) begin
      cmd_valid_d = 1'b0;
    end else begin
      cmd_valid_d = cmd_valid_q;
    end

    rd0_valid_d = accept_s && (owner_s == logic'(REQ0));
    rd1_valid_d = accept_s && (owner_s == logic'(REQ1));
    rd_last_d   = accept_s && i_ddr_rd_last;
    if (accept_s) begin
      rd_data_d = i_ddr_rd_data;
    end else begin
      rd_data_d = rd_data_q;
    end
    if (retire_s) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({grant_s, retire_s})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
    full_d = (count_d == MaxCnt);
    err_d  = err_q || (i_ddr_rd_valid && (count_q == '0));
  end

  // State and registered outputs; the tag RAM itself is left unreset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmd_valid_q  <= 1'b0;
      cmd_addr_q   <= '0;
      rd0_valid_q  <= 1'b0;
      rd1_valid_q  <= 1'b0;
      rd_data_q    <= '0;
      rd_last_q    <= 1'b0;
      count_q      <= '0;
      full_q       <= 1'b0;
      err_q        <= 1'b0;
      last_grant_q <= REQ1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      cmd_valid_q  <= cmd_valid_d;
      cmd_addr_q   <= cmd_addr_d;
      rd0_valid_q  <= rd0_valid_d;
      rd1_valid_q  <= rd1_valid_d;
      rd_data_q    <= rd_data_d;
      rd_last_q    <= rd_last_d;
      count_q      <= count_d;
      full_q       <= full_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  assign o_req0_ready    = grant_s && (gnt_id_s == REQ0);
  assign o_req1_ready    = grant_s && (gnt_id_s == REQ1);
  assign o_ddr_cmd_valid = cmd_valid_q;
  assign o_ddr_cmd_addr  = cmd_addr_q;
  assign o_rd0_valid     = rd0_valid_q;
  assign o_rd1_valid     = rd1_valid_q;
  assign o_rd_data       = rd_data_q;
  assign o_rd_last       = rd_last_q;
  assign o_outstanding   = count_q;
  assign o_full          = full_q;
  assign o_err           = err_q;

endmodule
